// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the two-requester register access arbiter.
package reg_arb_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned IDX_W   = $clog2(NUM_REQ);

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_e;

endpackage

// File: rtl/reg_arb_select.sv
// Combinational winner select between the two requesters.
// Build option: REG_ARB_FIXED_PRIORITY_EN selects fixed priority (requester 0
// wins ties) and removes the last-grant input; otherwise ties are round-robin.
module reg_arb_select
  import reg_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
`ifndef REG_ARB_FIXED_PRIORITY_EN
  input  logic [IDX_W-1:0]   last_grant_i,
`endif
  output logic [IDX_W-1:0]   grant_idx_c_o
);

  // Pick the winning index; a lone request always wins.
  always_comb begin
    grant_idx_c_o = IDX_W'(0);
`ifdef REG_ARB_FIXED_PRIORITY_EN
    if (!req_i[0] && req_i[1]) begin
      grant_idx_c_o = IDX_W'(1);
    end
`else
    if (req_i == 2'b10) begin
      grant_idx_c_o = IDX_W'(1);
    end else if (req_i == 2'b11) begin
      grant_idx_c_o = ~last_grant_i;
    end
`endif
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Shares one single-read/single-write register between two requesters.
// Build option: REG_ARB_FIXED_PRIORITY_EN (see reg_arb_select); when it is
// undefined, ties are broken round-robin using last_grant.
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ-1:0]   op_i,
  input  logic [WIDTH-1:0]     wdata0_i,
  input  logic [WIDTH-1:0]     wdata1_i,
  output logic [NUM_REQ-1:0]   ack_o,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 reg_write_enable_o,
  output logic [WIDTH-1:0]     reg_write_data_o,
  input  logic [WIDTH-1:0]     reg_read_data_i
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               we_q, we_d;
  logic [WIDTH-1:0]   wd_q, wd_d;
  logic [IDX_W-1:0]   grant_idx;
  logic               accept;

`ifndef REG_ARB_FIXED_PRIORITY_EN
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
`endif

  reg_arb_select u_select (
    .req_i         (req_i),
`ifndef REG_ARB_FIXED_PRIORITY_EN
    .last_grant_i  (last_grant_q),
`endif
    .grant_idx_c_o (grant_idx)
  );

  assign accept = (state_q == IDLE) && (|req_i);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req_i) state_d = ISSUE;
      ISSUE:   state_d = (op_q == OP_WRITE) ? ACK : CAPTURE;
      CAPTURE: state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latches, read capture and grant history.
  always_comb begin
    win_d   = win_q;
    op_d    = op_q;
    rdata_d = rdata_q;
`ifndef REG_ARB_FIXED_PRIORITY_EN
    last_grant_d = last_grant_q;
    if (state_q == ACK) last_grant_d = win_q;
`endif
    if (accept) begin
      win_d = grant_idx;
      op_d  = op_i[grant_idx];
    end
    if (state_q == CAPTURE) rdata_d = reg_read_data_i;
  end

  // Output decode from the upcoming state; the write-data register doubles as
  // the latch for the winner's wdata since it is only needed during ISSUE.
  always_comb begin
    ack_d = '0;
    we_d  = 1'b0;
    wd_d  = '0;
    if (state_d == ISSUE) begin
      we_d = (op_d == OP_WRITE);
      wd_d = (win_d == IDX_W'(1)) ? wdata1_i : wdata0_i;
    end
    if (state_d == ACK) ack_d[win_q] = 1'b1;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q   <= '0;
      op_q    <= OP_READ;
      rdata_q <= '0;
      ack_q   <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
`ifndef REG_ARB_FIXED_PRIORITY_EN
      last_grant_q <= IDX_W'(1);
`endif
    end else begin
      win_q   <= win_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
`ifndef REG_ARB_FIXED_PRIORITY_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign ack_o              = ack_q;
  assign rdata_o            = rdata_q;
  assign reg_write_enable_o = we_q;
  assign reg_write_data_o   = wd_q;

endmodule

// File: doc/reg_access_arbiter.md
# reg_access_arbiter

Two-requester access controller for the single-read/single-write register block. It shares one register instance between two clients by arbitrating read and write requests and driving the register's write_enable/write_data. It captures the register's read_data and returns it with a per-requester acknowledge. It sits between client logic and the register, and is the only driver of the register's write port.

## Interface

- WIDTH, 16, data width; must match the register's width parameter.

- clk  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_i  in  2  per-requester request; bit k for requester k.
- op_i  in  2  per-requester operation; 1 = write, 0 = read; sampled with req.
- wdata0_i  in  WIDTH  requester 0 write data.
- wdata1_i  in  WIDTH  requester 1 write data.
- ack_o  out  2  one-cycle completion pulse to the granted requester.
- rdata_o  out  WIDTH  read result; valid while the corresponding ack_o bit is high.
- reg_write_enable_o  out  1  to register write_enable.
- reg_write_data_o  out  WIDTH  to register write_data.
- reg_read_data_i  in  WIDTH  from register read_data.

## Operation

- FSM states: IDLE, ISSUE, CAPTURE, ACK.
- IDLE: if any req_i bit is high, pick a winner and latch its index, op and wdata, then go to ISSUE. Otherwise stay in IDLE.
- Arbitration: a single request wins outright. If both requesters assert, the winner is the one not granted last (round-robin). last_grant resets to 1, so requester 0 wins first.
- ISSUE: reg_write_enable_o = latched op; reg_write_data_o = latched data.
  - Write: go to ACK.
  - Read: go to CAPTURE. The register updates read_data at the end of ISSUE.
- CAPTURE: at the end of the cycle, rdata_q <= reg_read_data_i; go to ACK.
- ACK: ack_o[winner] = 1; update last_grant; go to IDLE.
- rdata_o holds the last captured value until the next read capture. Writes do not change it.
- Handshake: a requester holds req, op and wdata stable until its ack. Inputs are sampled only in IDLE, so changes after the grant are ignored. A req still high in the IDLE cycle after ack is treated as a new request.
- reg_write_enable_o is 0 in every state except ISSUE-with-write.
- reg_write_data_o is 0 outside ISSUE.

## Timing

- Reset values: state IDLE, ack_o 0, rdata_o 0, reg_write_enable_o 0, reg_write_data_o 0, last_grant 1.
- Write: req sampled at edge T, so ISSUE runs T..T+1 (one cycle of write_enable) and ACK runs T+1..T+2.
- Read: ISSUE runs T..T+1, CAPTURE runs T+1..T+2, and ACK with rdata_o valid runs T+2..T+3.
- Throughput: one op per 3 cycles (write) or 4 cycles (read), IDLE cycle included.
- Simultaneous requests: only one is serviced. The loser waits; because its req stays high, it wins the next IDLE under round-robin.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous).
  - The in-flight op is dropped with no ack.
  - A write is not guaranteed to have reached the register.
  - After reset release, the first IDLE edge services normally.

## Configuration

- REG_ARB_FIXED_PRIORITY_EN defined: requester 0 always wins when both request. last_grant is neither implemented nor used.
- Undefined (default): round-robin as described above.

## Structure

- Package reg_arb_pkg:
  - state enum (IDLE, ISSUE, CAPTURE, ACK);
  - op encoding constants OP_READ = 0, OP_WRITE = 1;
  - requester count localparam NUM_REQ = 2.
- One sub-module, reg_arb_select: combinational winner select from req_i and last_grant. The fixed-priority macro is handled there.
- reg_access_arbiter holds the FSM, the latches and rdata_q.

## Test plan

- Reset: hold reset_n low mid-clock -> all outputs 0 immediately; after release, no ack without req.
- Requester 0 writes 16'hA5A5 -> reg_write_enable_o high for exactly one cycle with data A5A5; ack_o = 2'b01 for one cycle, 2 cycles after the sampling edge.
- Requester 1 reads after that write -> ack_o = 2'b10 with rdata_o = 16'hA5A5, 3 cycles after the sampling edge; reg_write_enable_o stays 0 throughout.
- Both req held high, writes of 16'h0001 (req 0) and 16'h0002 (req 1):
  - default build: grant order 0,1,0,1;
  - with REG_ARB_FIXED_PRIORITY_EN: 0,0,0.
- Reset pulse during CAPTURE of a read -> no ack, rdata_o = 0; the next read by requester 0 returns the register value normally.
- Requester 0 writes 16'h1234, then reads back-to-back -> second ack carries rdata_o = 16'h1234; exactly one IDLE cycle between ACK and the next ISSUE.
